// File: rtl/timer_sequencer.sv
// Programmable interval timer: a free-running prescaler produces a tick
// every PRESCALE+1 RUN cycles, and the main count q advances once per tick
// up to a period latched at start. One-shot mode parks in EXPIRED at the
// terminal count; periodic mode wraps q to 0 and keeps running.
module timer_sequencer #(
  parameter int N        = 7,
  parameter int PW       = 7,
  parameter int PRESCALE = 127
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic         mode,
  input  logic [N-1:0] period,
  output logic [N-1:0] q,
  output logic         tick,
  output logic         done,
  output logic         busy,
  output logic [1:0]   state
);

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] RUN     = 2'b01;
  localparam logic [1:0] PAUSE   = 2'b10;
  localparam logic [1:0] EXPIRED = 2'b11;

  localparam logic [PW-1:0] P_TERM = PW'(PRESCALE);

  logic [PW-1:0] p;
  logic [N-1:0]  period_r;

  // Control FSM, prescaler and main count share one register block so the
  // priority arst > clear > stop > start is expressed in a single place.
  // tick/done default low so they can only ever be single-cycle pulses.
  always_ff @(posedge clk) begin
    if (arst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      q        <= '0;
      p        <= '0;
      period_r <= '0;
      tick     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (clear) begin
        state <= IDLE;
        busy  <= 1'b0;
        q     <= '0;
        p     <= '0;
      end else begin
        case (state)
          IDLE, EXPIRED: begin
            // Fresh start: the only place the period is captured.
            if (start) begin
              state    <= RUN;
              busy     <= 1'b1;
              period_r <= period;
              q        <= '0;
              p        <= '0;
            end
          end
          RUN: begin
            if (stop) begin
              // Pausing wins over a coincident prescaler wrap: p and q hold.
              state <= PAUSE;
            end else if (p == P_TERM) begin
              p    <= '0;
              tick <= 1'b1;
              if (q != period_r) begin
                q <= q + 1'b1;
              end else begin
                done <= 1'b1;
                if (mode) begin
                  q <= '0;
                end else begin
                  state <= EXPIRED;
                  busy  <= 1'b0;
                end
              end
            end else begin
              p <= p + 1'b1;
            end
          end
          PAUSE: begin
            // Resume keeps p, q and period_r exactly as they were.
            if (start) state <= RUN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer (N=4, PW=2, PRESCALE=3).
// The reference model tracks how many RUN cycles have elapsed since the last
// fresh start and derives tick/q/done from that count arithmetically.
module tb_timer_sequencer;

  logic       clk = 1'b0;
  logic       arst = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, mode = 1'b0;
  logic [3:0] period = '0;
  logic [3:0] q;
  logic       tick, done, busy;
  logic [1:0] state;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model
  int         m_state = 0;  // 0 idle, 1 run, 2 pause, 3 expired
  int         m_cnt   = 0;  // counting RUN cycles since last fresh start
  int         m_per   = 0;
  logic [3:0] m_q     = '0;
  logic       m_tick  = 1'b0;
  logic       m_done  = 1'b0;

  timer_sequencer #(.N(4), .PW(2), .PRESCALE(3)) dut (
    .clk(clk), .arst(arst), .start(start), .stop(stop), .clear(clear),
    .mode(mode), .period(period), .q(q), .tick(tick), .done(done),
    .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {state, busy, done, tick, q};
  endfunction

  function automatic logic [8:0] expv();
    logic b;
    b = (m_state == 1) || (m_state == 2);
    return {2'(m_state), b, m_done, m_tick, m_q};
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int k, r;
    m_tick = 1'b0;
    m_done = 1'b0;
    if (arst) begin
      m_state = 0; m_q = '0; m_cnt = 0; m_per = 0;
    end else if (clear) begin
      m_state = 0; m_q = '0; m_cnt = 0;
    end else begin
      case (m_state)
        0, 3: if (start) begin
          m_state = 1; m_per = int'(period); m_q = '0; m_cnt = 0;
        end
        1: if (stop) m_state = 2;
           else begin
             m_cnt++;
             if (m_cnt % 4 == 0) begin
               m_tick = 1'b1;
               k = m_cnt / 4;
               r = k % (m_per + 1);
               if (r == 0) begin
                 m_done = 1'b1;
                 if (mode) m_q = '0;
                 else m_state = 3;
               end else m_q = 4'(r);
             end
           end
        2: if (start) m_state = 1;
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit a, input bit cl, input bit st, input bit sp,
                      input bit md, input logic [3:0] pr);
    arst = a; clear = cl; start = st; stop = sp; mode = md; period = pr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 1, 0, 0, 4'd5);  // arst and start together: reset wins
    n_chk++;
    if (obs() !== 9'b0) $display("FAIL reset: got %b exp %b", obs(), 9'b0);
    else n_pass++;
    step(1, 1, 1, 1, 1, 4'd9);
    n_chk++;
    if ({state, busy, q} !== 7'b0) $display("FAIL reset_all_inputs: got %b exp 0", {state, busy, q});
    else n_pass++;
  endtask

  task automatic test_oneshot();
    int done_at = -1;
    step(1, 0, 0, 0, 0, 4'd0);
    step(0, 0, 1, 0, 0, 4'd2);
    for (int e = 1; e <= 16; e++) begin
      step(0, 0, 0, 0, 0, 4'd2);
      n_chk++;
      if (obs() !== expv()) $display("FAIL oneshot e%0d: got %b exp %b", e, obs(), expv());
      else n_pass++;
      if (done === 1'b1 && done_at < 0) done_at = e;
    end
    n_chk++;
    if (done_at !== 12) $display("FAIL oneshot_done_edge: got %0d exp 12", done_at);
    else n_pass++;
    n_chk++;
    if ({state, busy, q} !== 7'b11_0_0010) $display("FAIL oneshot_final: got %b exp 1100010", {state, busy, q});
    else n_pass++;
  endtask

  task automatic test_periodic();
    int dn[$];
    step(1, 0, 0, 0, 0, 4'd0);
    step(0, 0, 1, 0, 1, 4'd2);
    for (int e = 1; e <= 40; e++) begin
      step(0, 0, 0, 0, 1, 4'd2);
      n_chk++;
      if (obs() !== expv()) $display("FAIL periodic e%0d: got %b exp %b", e, obs(), expv());
      else n_pass++;
      if (done === 1'b1) dn.push_back(e);
    end
    n_chk++;
    if (dn.size() != 3 || dn[0] != 12 || dn[1] != 24 || dn[2] != 36)
      $display("FAIL periodic_done_edges: got %0d dones exp 3 at 12,24,36", dn.size());
    else n_pass++;
  endtask

  task automatic test_pause();
    int done_at = -1;
    step(1, 0, 0, 0, 0, 4'd0);
    step(0, 0, 1, 0, 0, 4'd2);
    for (int e = 1; e <= 22; e++) begin
      step(0, 0, (e == 11), (e >= 6 && e <= 10), 0, 4'd7);
      n_chk++;
      if (obs() !== expv()) $display("FAIL pause e%0d: got %b exp %b", e, obs(), expv());
      else n_pass++;
      if (done === 1'b1 && done_at < 0) done_at = e;
    end
    n_chk++;
    if (done_at !== 18) $display("FAIL pause_done_edge: got %0d exp 18", done_at);
    else n_pass++;
  endtask

  task automatic test_clear();
    int ndone = 0;
    int done_at = -1;
    step(1, 0, 0, 0, 0, 4'd0);
    step(0, 0, 1, 0, 1, 4'd2);
    for (int e = 1; e <= 30; e++) begin
      step(0, (e == 7), 0, 0, 1, 4'd2);
      n_chk++;
      if (obs() !== expv()) $display("FAIL clear e%0d: got %b exp %b", e, obs(), expv());
      else n_pass++;
      if (done === 1'b1) ndone++;
    end
    n_chk++;
    if (ndone != 0 || state !== 2'b00) $display("FAIL clear_idle: got dones=%0d state=%b exp 0/00", ndone, state);
    else n_pass++;
    step(0, 0, 1, 0, 0, 4'd1);
    for (int e = 1; e <= 12; e++) begin
      step(0, 0, 0, 0, 0, 4'd6);
      if (done === 1'b1 && done_at < 0) done_at = e;
    end
    n_chk++;
    if (done_at !== 8) $display("FAIL clear_restart_done: got %0d exp 8", done_at);
    else n_pass++;
  endtask

  task automatic test_collisions();
    step(1, 0, 0, 0, 0, 4'd0);
    step(0, 0, 1, 0, 0, 4'd3);
    step(0, 0, 1, 1, 0, 4'd3);  // stop and start in RUN
    n_chk++;
    if (state !== 2'b10 || busy !== 1'b1) $display("FAIL stop_start_run: got state=%b busy=%b exp 10/1", state, busy);
    else n_pass++;
    // fresh start, then stop exactly on the prescaler wrap edge
    step(0, 1, 0, 0, 0, 4'd3);
    step(0, 0, 1, 0, 0, 4'd3);
    for (int e = 1; e <= 3; e++) step(0, 0, 0, 0, 0, 4'd3);
    step(0, 0, 0, 1, 0, 4'd3);
    n_chk++;
    if ({state, tick, q} !== 7'b10_0_0000) $display("FAIL stop_at_wrap: got %b exp 1000000", {state, tick, q});
    else n_pass++;
    step(0, 0, 1, 0, 0, 4'd3);
    step(0, 0, 0, 0, 0, 4'd3);
    n_chk++;
    if ({state, tick, q} !== 7'b01_1_0001) $display("FAIL resume_tick: got %b exp 0110001", {state, tick, q});
    else n_pass++;
  endtask

  task automatic test_period0();
    int nt = 0, nd = 0, bad_q = 0;
    step(1, 0, 0, 0, 0, 4'd0);
    step(0, 0, 1, 0, 1, 4'd0);
    for (int e = 1; e <= 24; e++) begin
      step(0, 0, (e == 5), 0, 1, 4'd5);  // start while RUN: ignored
      n_chk++;
      if (obs() !== expv()) $display("FAIL period0 e%0d: got %b exp %b", e, obs(), expv());
      else n_pass++;
      if (tick === 1'b1) nt++;
      if (done === 1'b1) nd++;
      if (q !== 4'd0) bad_q++;
    end
    n_chk++;
    if (nt != 6 || nd != 6 || bad_q != 0)
      $display("FAIL period0_counts: got ticks=%0d dones=%0d nonzero_q=%0d exp 6/6/0", nt, nd, bad_q);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    bit a, cl, st, sp, md;
    logic [3:0] pr;
    step(1, 0, 0, 0, 0, 4'd0);
    for (int e = 0; e < 2000; e++) begin
      a  = ($urandom_range(0, 299) == 0);
      cl = ($urandom_range(0, 79) == 0);
      sp = ($urandom_range(0, 24) == 0);
      st = ($urandom_range(0, 7) == 0);
      md = 1'($urandom);
      pr = 4'($urandom_range(0, 15));
      step(a, cl, st, sp, md, pr);
      n_chk++;
      if (obs() !== expv()) begin
        errs++;
        if (errs <= 10) $display("FAIL random c%0d: got %b exp %b", e, obs(), expv());
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_clear();
    test_collisions();
    test_period0();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
